// File: rtl/ram_burst_reader_pkg.sv
// Shared types and default widths for the RAM burst reader slice.
// FSM state encoding lives here so the bench and any wrappers agree on it.
package gusn_pkg;

   typedef enum logic [1:0] {RB_IDLE, RB_RUN, RB_DRAIN, RB_DONE} rb_state_t;

   localparam int RB_ADDR_W = 8;
   localparam int RB_DATA_W = 8;
   localparam int RB_LEN_W  = RB_ADDR_W + 1;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command, RAM read port and output stream of the burst reader in one bundle.
// master = the reader itself, slave = the command source / RAM / stream sink side.
interface ram_burst_reader_if
   import gusn_pkg::*;
#(
   parameter int ADDR_W = RB_ADDR_W,
   parameter int DATA_W = RB_DATA_W,
   parameter int LEN_W  = RB_LEN_W
) ();

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] ram_addr_read;
   logic [DATA_W-1:0] ram_data_read;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      input  start, base_addr, length, ram_data_read, out_ready,
      output busy, done, ram_addr_read, out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, length, ram_data_read, out_ready,
      input  busy, done, ram_addr_read, out_valid, out_data, out_last
   );

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry FIFO holding RAM read data that the stream sink has not yet taken.
// Push and pop may coincide at any count; the caller guarantees no overflow/underflow.
module ram_rd_skid_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;

   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a wrapping burst of words from a 1-cycle-latency RAM and streams them out with last.
// First beat 2 clk after start; 1 beat/clk under full ready, reads throttled to 2 outstanding.
module ram_burst_reader
   import gusn_pkg::*;
#(
   parameter int ADDR_W = RB_ADDR_W,
   parameter int DATA_W = RB_DATA_W,
   parameter int LEN_W  = RB_LEN_W
) (
   input  logic clk,
   input  logic rst_n,
   ram_burst_reader_if.master bus
);

   rb_state_t         state, state_nxt;
   logic [ADDR_W-1:0] ram_addr;
   logic [LEN_W-1:0]  issue_left;
   logic [LEN_W-1:0]  beat_left;
   logic              inflight;
   logic              issue;
   logic              pop;
   logic              out_valid;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [1:0]        fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic [2:0]        occupancy;

   // A read landing on an empty FIFO is presented straight away, which is what
   // makes the first beat appear 2 clk after start.
   assign fifo_empty = (fifo_count == 2'd0);
   assign out_valid  = !fifo_empty || inflight;
   assign pop        = out_valid && bus.out_ready;
   assign fifo_pop   = pop && !fifo_empty;
   assign fifo_push  = inflight && !(fifo_empty && bus.out_ready);
   assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

   ram_rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (bus.ram_data_read),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .count     (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         RB_IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.length == '0) ? RB_DONE : RB_RUN;
            end
         end
         RB_RUN: begin
            if (occupancy < 3'd2) begin
               issue = 1'b1;
               if (issue_left == LEN_W'(1)) begin
                  state_nxt = RB_DRAIN;
               end
            end
         end
         RB_DRAIN: begin
            if (pop && beat_left == LEN_W'(1)) begin
               state_nxt = RB_DONE;
            end
         end
         RB_DONE:  state_nxt = RB_IDLE;
         default:  state_nxt = RB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RB_IDLE;
         ram_addr   <= '0;
         issue_left <= '0;
         beat_left  <= '0;
         inflight   <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (state == RB_IDLE && bus.start) begin
            ram_addr   <= bus.base_addr;
            issue_left <= bus.length;
            beat_left  <= bus.length;
         end else begin
            if (issue) begin
               ram_addr   <= ram_addr + ADDR_W'(1);
               issue_left <= issue_left - LEN_W'(1);
            end
            if (pop) begin
               beat_left <= beat_left - LEN_W'(1);
            end
         end
      end
   end

   assign bus.ram_addr_read = ram_addr;
   assign bus.busy          = (state != RB_IDLE);
   assign bus.done          = (state == RB_DONE);
   assign bus.out_valid     = out_valid;
   assign bus.out_last      = out_valid && (beat_left == LEN_W'(1));
   assign bus.out_data      = !fifo_empty ? fifo_head :
                              (inflight ? bus.ram_data_read : '0);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench: bursts push expected beats from a word-level RAM model, a monitor pops on handshake.
module tb_ram_burst_reader;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] mem [256];
   beat_t      exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         beats  = 0;
   int         rmode  = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   ram_burst_reader_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) bus ();

   ram_burst_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.ram_data_read <= mem[bus.ram_addr_read];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sink ready: 0 = always, 1 = 1,0,0 repeating, 2 = random
   initial begin
      int pc = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1:       begin bus.out_ready = (pc % 3 == 0); pc++; end
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("occupancy_le_2", int'(int'(dut.fifo_count) + int'(dut.inflight) <= 2), 1);
         check("no_pop_empty", int'(dut.fifo_pop && dut.fifo_count == 2'd0), 0);
         if (prev_stall) begin
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_data", int'(bus.out_data), int'(prev_data));
            check("stall_last", int'(bus.out_last), int'(prev_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", int'(bus.out_data), -1);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", int'(bus.out_data), int'(e.d));
               check("beat_last", int'(bus.out_last), int'(e.l));
               beats++;
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   // Returns one time unit into the cycle after start was sampled.
   task automatic start_burst(int b, int len);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.base_addr = 8'(b);
      bus.length    = 9'(len);
      for (int i = 0; i < len; i++) begin
         beat_t e;
         e.d = mem[(b + i) % 256];
         e.l = (i == len - 1);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.base_addr = 8'($urandom);
      bus.length    = 9'($urandom);
   endtask

   task automatic wait_done(int max_cyc);
      for (int n = 0; n < max_cyc; n++) begin
         @(negedge clk);
         if (bus.done) begin
            check("queue_drained_at_done", exp_q.size(), 0);
            return;
         end
      end
      check("done_timeout", 0, 1);
      exp_q.delete();
   endtask

   // Full-ready burst: beats in cycles 2..len+1, done/busy-end at len+2 (cycle 1 if len==0).
   task automatic timed_burst(int b, int len);
      int dc;
      dc = (len == 0) ? 1 : len + 2;
      start_burst(b, len);
      for (int c = 1; c <= dc + 1; c++) begin
         @(negedge clk);
         check($sformatf("valid_c%0d", c), int'(bus.out_valid), int'(c >= 2 && c <= len + 1));
         check($sformatf("done_c%0d", c), int'(bus.done), int'(c == dc));
         check($sformatf("busy_c%0d", c), int'(bus.busy), int'(c <= dc));
      end
      check("queue_empty_after_timed", exp_q.size(), 0);
   endtask

   initial begin
      int b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.length    = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_last", int'(bus.out_last), 0);
      check("rst_addr", int'(bus.ram_addr_read), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      rmode = 0;
      timed_burst(8'h10, 4);
      timed_burst(8'h33, 0);

      rmode = 1;
      start_burst(8'h50, 8);
      wait_done(200);

      rmode = 0;
      timed_burst(8'hFE, 4);
      rmode = 2;
      start_burst(8'h80, 256);
      wait_done(3000);

      // Second start while running must be ignored
      rmode = 0;
      start_burst(8'h20, 6);
      @(posedge clk);
      #1;
      bus.start = 1'b1; bus.base_addr = 8'h90; bus.length = 9'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(100);
      repeat (4) @(negedge clk);
      check("no_extra_burst_valid", int'(bus.out_valid), 0);

      // Asynchronous reset after three beats
      b0 = beats;
      start_burst(8'h40, 10);
      for (int n = 0; n < 100 && beats < b0 + 3; n++) @(negedge clk);
      check("three_beats_before_reset", beats - b0, 3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_done", int'(bus.done), 0);
      check("mid_rst_valid", int'(bus.out_valid), 0);
      check("mid_rst_last", int'(bus.out_last), 0);
      check("mid_rst_data", int'(bus.out_data), 0);
      check("mid_rst_addr", int'(bus.ram_addr_read), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("held_rst_done", int'(bus.done), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rmode = 2;
      start_burst(8'h70, 5);
      wait_done(100);

      for (int k = 0; k < 4; k++) begin
         start_burst($urandom_range(0, 255), $urandom_range(1, 20));
         wait_done(200);
      end
      rmode = 0;
      timed_burst($urandom_range(0, 255), $urandom_range(1, 6));

      repeat (3) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
